clk_div_ctrl: RTL

Programmable clock-enable controller that sequences a divided clock for downstream logic. It holds the active divisor, accepts new divisor and burst settings through a valid/ready handshake, and applies them only at period boundaries. It runs either free-running or for a fixed number of periods, and produces a one-cycle tick pulse plus a duty-cycled clk_out. It sits between the control/config logic and any block needing a slower timing reference.

---
 rtl/clk_div_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable controller: divided clk_out, tick and done pulses,
// with divisor/burst updates accepted by handshake and applied on period wrap.
module clk_div_ctrl #(
   parameter int CNT_W       = 16,
   parameter int BURST_W     = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CNT_W-1:0]   cfg_div,
   input  logic [BURST_W-1:0] cfg_burst,
   input  logic               start,
   input  logic               stop,
   output logic               busy,
   output logic               tick,
   output logic               clk_out,
   output logic               done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_STOP = 2'd2;

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_div;
   logic [BURST_W-1:0] r_burst;
   logic               r_pend;
   logic [CNT_W-1:0]   r_pdiv;
   logic [BURST_W-1:0] r_pburst;
   logic [BURST_W-1:0] r_rem;
   logic               r_tick;
   logic               r_clk;
   logic               r_done;

   logic               w_cap;
   logic               w_apply;
   logic [CNT_W-1:0]   w_cfg_div;
   logic [CNT_W-1:0]   w_div_n;
   logic [BURST_W-1:0] w_burst_n;
   logic [1:0]         w_state_n;
   logic [CNT_W-1:0]   w_cnt_n;
   logic [BURST_W-1:0] w_rem_n;
   logic               w_run_n;
   logic               w_tick_n;
   logic               w_clk_n;
   logic               w_done_n;

   always_comb begin
      w_cap     = cfg_valid && !r_pend;
      w_cfg_div = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;
      // Pending settings land immediately when idle, else only at the wrap
      w_apply   = r_pend && (r_state == S_IDLE || r_tick);
      w_div_n   = w_apply ? r_pdiv : r_div;
      w_burst_n = w_apply ? r_pburst : r_burst;
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_rem_n   = r_rem;
      case (r_state)
         S_IDLE: begin
            if (start && !stop) begin
               w_state_n = S_RUN;
               w_cnt_n   = '0;
               w_rem_n   = w_burst_n;
            end
         end
         default: begin
            if (r_state == S_RUN && stop)
               w_state_n = S_STOP;
            if (r_tick) begin
               w_cnt_n = '0;
               if (r_rem != '0)
                  w_rem_n = r_rem - BURST_W'(1);
               // done already flagged this tick: stop and burst end merge here
               if (r_done)
                  w_state_n = S_IDLE;
            end else begin
               w_cnt_n = r_cnt + CNT_W'(1);
            end
         end
      endcase
      w_run_n  = (w_state_n != S_IDLE);
      w_tick_n = w_run_n && (w_cnt_n == w_div_n - CNT_W'(1));
      w_clk_n  = w_run_n && (w_cnt_n < (w_div_n >> 1));
      w_done_n = w_tick_n &&
                 (w_state_n == S_STOP || w_rem_n == BURST_W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_div    <= CNT_W'(DEFAULT_DIV);
         r_burst  <= '0;
         r_pend   <= 1'b0;
         r_pdiv   <= CNT_W'(DEFAULT_DIV);
         r_pburst <= '0;
         r_rem    <= '0;
         r_tick   <= 1'b0;
         r_clk    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_run_n ? w_cnt_n : '0;
         r_div   <= w_div_n;
         r_burst <= w_burst_n;
         r_rem   <= w_rem_n;
         r_tick  <= w_tick_n;
         r_clk   <= w_clk_n;
         r_done  <= w_done_n;
         if (w_cap) begin
            r_pend   <= 1'b1;
            r_pdiv   <= w_cfg_div;
            r_pburst <= cfg_burst;
         end else if (w_apply) begin
            r_pend <= 1'b0;
         end
      end
   end

   assign cfg_ready = !r_pend;
   assign busy      = (r_state != S_IDLE);
   assign tick      = r_tick;
   assign clk_out   = r_clk;
   assign done      = r_done;

endmodule
